dqs_burst_sequencer: RTL



---
 rtl/ddr_phy_pkg.sv | 25 ++
 rtl/dqs_burst_sequencer_edge_counter.sv | 55 +++++
 rtl/dqs_burst_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_phy_pkg.sv
// Shared definitions for the DDR PHY byte-lane control blocks.
package ddr_phy_pkg;

    // Sequencer states for dqs_burst_sequencer.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WPRE   = 3'd1,
        ST_WBURST = 3'd2,
        ST_WPOST  = 3'd3,
        ST_RLAT   = 3'd4,
        ST_RWIN   = 3'd5,
        ST_TURN   = 3'd6
    } dqs_state_e;

    // Default DQS timing in clk cycles (one clk = one DQS half-period).
    localparam int DQS_PRE_CYCLES  = 2;
    localparam int DQS_POST_CYCLES = 1;
    localparam int DQS_TURN_CYCLES = 2;

    // True for the states in which this lane owns the DQS pad.
    function automatic logic dqs_drives_pad(input dqs_state_e s);
        return (s == ST_WPRE) || (s == ST_WBURST) || (s == ST_WPOST);
    endfunction

endpackage

// File: rtl/dqs_burst_sequencer_edge_counter.sv
// Counts rising edges of the returned DQS strobe during a read capture
// window and compares the count against the expected N+1 edges.
module dqs_edge_counter #(
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 dqs_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 mismatch_o
);

    localparam int CW = LEN_WIDTH + 1;

    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] target;
    logic          rise;

    assign rise   = en_i && dqs_i && !prev_q;
    assign target = CW'(len_i) + CW'(1);

    // Next sample/count: clear wins so a strobe already high on window
    // entry is seen as an edge; the count saturates instead of wrapping.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            prev_d = 1'b0;
            cnt_d  = '0;
        end else if (en_i) begin
            prev_d = dqs_i;
            if (rise && (cnt_q != {CW{1'b1}})) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // The verdict includes the edge seen in the current (last) window cycle.
    assign mismatch_o = (cnt_d != target);

    // Sample and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dqs_burst_sequencer.sv
// DQS burst sequencer for one byte lane: drives write preamble, toggling
// strobe and postamble; for reads releases the pad, waits the latency,
// opens the capture window and checks the received edge count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | pad released, waiting for wr_start/rd_start
// ST_WPRE   | write preamble, pad driven low
// ST_WBURST | write strobe toggling 1,0,1,0...
// ST_WPOST  | write postamble, pad driven low
// ST_RLAT   | read latency countdown, pad released
// ST_RWIN   | read capture window open, counting received edges
// ST_TURN   | bus turnaround, pad released
//
// The done cycle itself is released and idle, so it serves as the last
// turnaround cycle: ST_TURN occupies TURN_CYCLES-1 cycles, and with
// TURN_CYCLES of 0 or 1 the burst ends straight into IDLE.
module dqs_burst_sequencer
    import ddr_phy_pkg::*;
#(
    parameter int PRE_CYCLES  = DQS_PRE_CYCLES,
    parameter int POST_CYCLES = DQS_POST_CYCLES,
    parameter int TURN_CYCLES = DQS_TURN_CYCLES,
    parameter int LEN_WIDTH   = 4,
    parameter int LAT_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_start_i,
    input  logic                 rd_start_i,
    input  logic [LEN_WIDTH-1:0] burst_len_i,
    input  logic [LAT_WIDTH-1:0] rd_lat_i,
    output logic                 dqs_data_o,
    output logic                 dqs_tri_o,
    input  logic                 dqs_received_i,
    output logic                 rd_window_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 reject_o,
    output logic                 rd_err_o
);

    localparam int CNT_W_RAW = (LEN_WIDTH + 1 > LAT_WIDTH) ? LEN_WIDTH + 1 : LAT_WIDTH;
    localparam int CNT_W     = (CNT_W_RAW > 4) ? CNT_W_RAW : 4;

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = (TURN_CYCLES > 1) ? CNT_W'(TURN_CYCLES - 2) : '0;
    localparam bit               TURN_SKIP = (TURN_CYCLES <= 1);

    dqs_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 err_q, err_d;

    logic                 tri_q, tri_d;
    logic                 data_q, data_d;
    logic                 win_q, win_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 reject_q, reject_d;
    logic                 rd_err_q, rd_err_d;

    logic                 tc;
    logic [CNT_W-1:0]     burst_load;
    logic                 edge_clear;
    logic                 edge_en;
    logic                 edge_mismatch;

    assign tc         = (cnt_q == '0);
    assign burst_load = CNT_W'({len_q, 1'b1});
    assign edge_clear = (state_d == ST_RWIN) && (state_q != ST_RWIN);
    assign edge_en    = (state_q == ST_RWIN);

    dqs_edge_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_edge_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (edge_clear),
        .en_i       (edge_en),
        .dqs_i      (dqs_received_i),
        .len_i      (len_q),
        .mismatch_o (edge_mismatch)
    );

    // Next-state, down-counter and latched burst parameters.
    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? cnt_q : (cnt_q - CNT_W'(1));
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (wr_start_i) begin
                    state_d = ST_WPRE;
                    cnt_d   = PRE_LOAD;
                    len_d   = burst_len_i;
                    err_d   = 1'b0;
                end else if (rd_start_i) begin
                    len_d = burst_len_i;
                    err_d = 1'b0;
                    if (rd_lat_i == '0) begin
                        state_d = ST_RWIN;
                        cnt_d   = CNT_W'({burst_len_i, 1'b1});
                    end else begin
                        state_d = ST_RLAT;
                        cnt_d   = CNT_W'(rd_lat_i) - CNT_W'(1);
                    end
                end
            end
            ST_WPRE: begin
                if (tc) begin
                    state_d = ST_WBURST;
                    cnt_d   = burst_load;
                end
            end
            ST_WBURST: begin
                if (tc) begin
                    state_d = ST_WPOST;
                    cnt_d   = POST_LOAD;
                end
            end
            ST_WPOST: begin
                if (tc) begin
                    state_d = TURN_SKIP ? ST_IDLE : ST_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_RLAT: begin
                if (tc) begin
                    state_d = ST_RWIN;
                    cnt_d   = burst_load;
                end
            end
            ST_RWIN: begin
                if (tc) begin
                    err_d   = edge_mismatch;
                    state_d = TURN_SKIP ? ST_IDLE : ST_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // the registered outputs line up with the state they describe.
    always_comb begin
        tri_d    = !dqs_drives_pad(state_d);
        data_d   = (state_d == ST_WBURST) && cnt_d[0];
        win_d    = (state_d == ST_RWIN);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        rd_err_d = done_d && err_d;
        reject_d = ((wr_start_i || rd_start_i) && (state_q != ST_IDLE)) ||
                   ((state_q == ST_IDLE) && wr_start_i && rd_start_i);
    end

    // State, counter and burst-parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Output registers; reset releases the pad asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_q    <= 1'b1;
            data_q   <= 1'b0;
            win_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            tri_q    <= tri_d;
            data_q   <= data_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            reject_q <= reject_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign dqs_tri_o   = tri_q;
    assign dqs_data_o  = data_q;
    assign rd_window_o = win_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign reject_o    = reject_q;
    assign rd_err_o    = rd_err_q;

endmodule
